// File: rtl/tempsens_pkg.sv
// Shared constants for the ring-oscillator measurement sequencer:
// UART command bytes, FSM state encodings and the log2n saturation helper.
package tempsens_pkg;

  localparam logic [7:0] CMD_MEAS   = 8'h4D;
  localparam logic [7:0] CMD_NSET   = 8'h4E;
  localparam logic [7:0] CMD_RESEND = 8'h52;
  localparam logic [7:0] CMD_ABORT  = 8'h58;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARM     = 4'd1;
  localparam logic [3:0] S_GATE    = 4'd2;
  localparam logic [3:0] S_SETTLE  = 4'd3;
  localparam logic [3:0] S_CAPTURE = 4'd4;
  localparam logic [3:0] S_DIVIDE  = 4'd5;
  localparam logic [3:0] S_SEND_LO = 4'd6;
  localparam logic [3:0] S_WAIT_LO = 4'd7;
  localparam logic [3:0] S_SEND_HI = 4'd8;
  localparam logic [3:0] S_WAIT_HI = 4'd9;

  localparam logic [2:0] LOG2N_MAX = 3'd4;

  function automatic logic [2:0] sat_log2n(input logic [2:0] v);
    return (v > LOG2N_MAX) ? LOG2N_MAX : v;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
// Ports: clk, reset (sync, active-high), load_i/val_i load, done_o flag.
module gate_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: UART commands start averaged
// gate/settle/capture cycles and the CW-bit result is sent as two bytes.
// Ports: clk, reset, rx_data/rx_ready (commands), tx_busy/tx_start/tx_data
// (transmit handshake), count/osc_en/cnt_clr (oscillator counter),
// result/result_valid (averaged value), busy (not idle).
module ro_meas_sequencer
  import tempsens_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          tx_busy,
  input  logic [CW-1:0] count,
  output logic          osc_en,
  output logic          cnt_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [CW-1:0] result,
  output logic          result_valid,
  output logic          busy
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ?
                        GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

  logic [3:0]    state_q, state_d;
  logic [2:0]    log2n_q, log2n_d;
  logic          pend_q, pend_d;
  logic [CW+3:0] acc_q, acc_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] res_q, res_d;
  logic          rv_q, rv_d;
  logic [7:0]    txd_q, txd_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          abort;

  gate_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  assign abort = rx_ready && (rx_data == CMD_ABORT) &&
                 (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    log2n_d  = log2n_q;
    pend_d   = pend_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    res_d    = res_q;
    rv_d     = 1'b0;
    txd_d    = txd_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          if (pend_q) begin
            // Byte after 'N' is its argument; 'X' drops it instead.
            pend_d = 1'b0;
            if (rx_data != CMD_ABORT) begin
              log2n_d = sat_log2n(rx_data[2:0]);
            end
          end else if (rx_data == CMD_MEAS) begin
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_ARM;
          end else if (rx_data == CMD_NSET) begin
            pend_d = 1'b1;
          end else if (rx_data == CMD_RESEND) begin
            txd_d   = 8'(res_q);
            state_d = S_SEND_LO;
          end
        end
      end
      S_ARM: begin
        tmr_load = 1'b1;
        tmr_val  = GATE_LD;
        state_d  = S_GATE;
      end
      S_GATE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_done) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        acc_d = acc_q + (CW+4)'(count);
        idx_d = idx_q + 5'd1;
        if (idx_d == (5'd1 << log2n_q)) begin
          state_d = S_DIVIDE;
        end else begin
          state_d = S_ARM;
        end
      end
      S_DIVIDE: begin
        res_d   = CW'(acc_q >> log2n_q);
        rv_d    = 1'b1;
        txd_d   = 8'(res_d);
        state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          txd_d   = 8'(res_q >> 8);
          state_d = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any in-flight update, result included.
    if (abort) begin
      state_d = S_IDLE;
      res_d   = res_q;
      rv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      log2n_q <= '0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      log2n_q <= log2n_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      txd_q   <= txd_d;
    end
  end

  assign osc_en       = (state_q == S_GATE);
  assign cnt_clr      = (state_q == S_ARM);
  assign tx_start     = (state_q == S_SEND_LO) ||
                        (state_q == S_SEND_HI);
  assign tx_data      = txd_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Randomised self-checking bench for ro_meas_sequencer with a UART
// responder, a counter model fed from a sample queue, and an averaging model.
module tb_ro_meas_sequencer;

  localparam int G  = 20;
  localparam int S  = 2;
  localparam int CW = 16;

  localparam logic [7:0] B_M = 8'h4D;
  localparam logic [7:0] B_N = 8'h4E;
  localparam logic [7:0] B_R = 8'h52;
  localparam logic [7:0] B_X = 8'h58;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_busy;
  logic [CW-1:0] count;
  logic          osc_en, cnt_clr, tx_start, result_valid, busy;
  logic [7:0]    tx_data;
  logic [CW-1:0] result;

  int checks = 0;
  int failures = 0;

  int clr_n, rv_n, resend_n, run_len;
  int uart_len = 2;
  int gates[$];
  logic [7:0] sent[$];
  logic [CW-1:0] smp_q[$];

  int log2n_m;
  logic [CW-1:0] result_m;

  always #5 clk = ~clk;

  ro_meas_sequencer #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .CW            (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_busy      (tx_busy),
    .count        (count),
    .osc_en       (osc_en),
    .cnt_clr      (cnt_clr),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse counts and gate window widths.
  initial begin
    clr_n = 0; rv_n = 0; run_len = 0;
    forever begin
      @(negedge clk);
      if (cnt_clr) clr_n++;
      if (result_valid) rv_n++;
      if (osc_en) run_len++;
      else if (run_len > 0) begin
        gates.push_back(run_len);
        run_len = 0;
      end
    end
  end

  // Counter model: each clear loads the next sample value.
  initial begin
    count = '0;
    forever begin
      @(negedge clk);
      if (cnt_clr) count = (smp_q.size() > 0) ? smp_q.pop_front() : '0;
    end
  end

  // UART responder: latches a byte, holds busy for uart_len cycles.
  initial begin
    tx_busy = 1'b0;
    resend_n = 0;
    forever begin
      @(negedge clk);
      if (tx_start && !tx_busy) begin
        sent.push_back(tx_data);
        tx_busy = 1'b1;
        @(negedge clk);
        check("start_drop", {31'b0, tx_start}, 0);
        for (int i = 1; i < uart_len; i++) begin
          @(negedge clk);
          if (tx_start) resend_n++;
        end
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    bit seen;
    t = 0;
    while (t < 20 && !busy) begin
      @(negedge clk);
      t++;
    end
    seen = busy;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done", {31'b0, seen && !busy}, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_obs();
    clr_n = 0;
    rv_n = 0;
    resend_n = 0;
    gates.delete();
    sent.delete();
  endtask

  task automatic check_tx(input logic [CW-1:0] e);
    logic [31:0] b0, b1;
    b0 = (sent.size() > 0) ? 32'(sent[0]) : 32'hFFFF_FFFF;
    b1 = (sent.size() > 1) ? 32'(sent[1]) : 32'hFFFF_FFFF;
    check("tx_n", sent.size(), 2);
    check("tx_lo", b0, 32'(e[7:0]));
    check("tx_hi", b1, 32'(e[15:8]));
    check("resend", resend_n, 0);
  endtask

  task automatic set_n(input logic [7:0] b);
    int v;
    send_byte(B_N);
    send_byte(b);
    v = int'(b[2:0]);
    if (b != B_X) log2n_m = (v > 4) ? 4 : v;
  endtask

  task automatic fill(input int n, input bit all_max);
    for (int i = 0; i < n; i++)
      smp_q.push_back(all_max ? 16'hFFFF : 16'($urandom_range(0, 65535)));
  endtask

  // Reference: mean of 2^log2n samples by plain division.
  task automatic run_m();
    longint sum;
    int ns, bad;
    logic [CW-1:0] e;
    ns = 1 << log2n_m;
    sum = 0;
    for (int i = 0; i < ns; i++) sum += longint'(smp_q[i]);
    e = CW'(sum / longint'(ns));
    clear_obs();
    send_byte(B_M);
    wait_done();
    check("result", 32'(result), 32'(e));
    check("rv_n", rv_n, 1);
    check("clr_n", clr_n, ns);
    check("gate_n", gates.size(), ns);
    bad = 0;
    foreach (gates[i]) if (gates[i] != G) bad++;
    check("gate_w", bad, 0);
    check_tx(e);
    result_m = e;
  endtask

  task automatic do_resend();
    clear_obs();
    send_byte(B_R);
    wait_done();
    check_tx(result_m);
    check("r_rv", rv_n, 0);
    check("r_clr", clr_n, 0);
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_osc"}, {31'b0, osc_en}, 0);
    check({tag, "_clr"}, {31'b0, cnt_clr}, 0);
    check({tag, "_txs"}, {31'b0, tx_start}, 0);
    check({tag, "_txd"}, 32'(tx_data), 0);
    check({tag, "_res"}, 32'(result), 0);
    check({tag, "_rv"}, {31'b0, result_valid}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    int t;
    logic [7:0] b;
    reset = 1'b1;
    rx_ready = 1'b0;
    rx_data = '0;
    log2n_m = 0;
    result_m = '0;
    repeat (3) @(negedge clk);
    check_rst_outs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 0);

    // Single sample, log2n = 0.
    uart_len = 3;
    smp_q.push_back(16'h1234);
    run_m();

    // Four-sample average.
    set_n(8'h02);
    smp_q.push_back(16'd100);
    smp_q.push_back(16'd200);
    smp_q.push_back(16'd300);
    smp_q.push_back(16'd400);
    run_m();

    // Saturated log2n with full-scale samples.
    set_n(8'h07);
    fill(16, 1'b1);
    run_m();

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do b = 8'($urandom_range(0, 255));
        while (b == B_M || b == B_N || b == B_R || b == B_X);
        send_byte(b);
        repeat (3) @(negedge clk);
        check("ignore", {31'b0, busy}, 0);
      end
      if ($urandom_range(0, 1) == 1) set_n(8'($urandom_range(0, 255)));
      uart_len = $urandom_range(1, 6);
      fill(1 << log2n_m, 1'b0);
      run_m();
      if ($urandom_range(0, 2) == 0) do_resend();
    end

    // Abort during the second gate window.
    uart_len = 2;
    set_n(8'h01);
    fill(2, 1'b0);
    clear_obs();
    send_byte(B_M);
    t = 0;
    while (clr_n < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("x_reach", {31'b0, clr_n == 2}, 1);
    repeat (5) @(negedge clk);
    check("x_pre", {31'b0, osc_en}, 1);
    rx_data = B_X;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("x_osc", {31'b0, osc_en}, 0);
    check("x_busy", {31'b0, busy}, 0);
    check("x_txs", {31'b0, tx_start}, 0);
    repeat (40) @(negedge clk);
    check("x_res", 32'(result), 32'(result_m));
    check("x_rv", rv_n, 0);
    check("x_tx", sent.size(), 0);
    smp_q.delete();

    // 'N' then 'X' drops the pending argument; 'M' still measures.
    send_byte(B_N);
    send_byte(B_X);
    fill(2, 1'b0);
    run_m();

    // Reset beats a simultaneous command.
    @(negedge clk);
    reset = 1'b1;
    rx_data = B_M;
    rx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_win", {31'b0, busy}, 0);
    log2n_m = 0;
    result_m = '0;

    // Long transmitter busy.
    uart_len = 50;
    fill(1, 1'b0);
    run_m();

    // Reset while waiting on the low byte.
    smp_q.push_back(16'hABCD);
    clear_obs();
    send_byte(B_M);
    t = 0;
    while (!(busy && tx_busy && !tx_start) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("wl_reach", {31'b0, busy && tx_busy && !tx_start}, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_rst_outs("wl");
    reset = 1'b0;
    log2n_m = 0;
    result_m = '0;
    t = 0;
    while (tx_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    uart_len = 2;
    do_resend();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_meas_sequencer.md
RO_MEAS_SEQUENCER -- requirements
Module: ro_meas_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 1000: clk cycles osc_en stays high per sample window.
REQ-002 Parameter SETTLE_CYCLES, default 2: clk cycles between osc_en fall and count capture.
REQ-003 Parameter CW, default 16: width of count and result.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_data  in  8  command byte from UART receiver.
REQ-007 rx_ready  in  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 tx_busy  in  1  UART transmitter busy level.
REQ-009 count  in  CW  ring-oscillator edge counter value.
REQ-010 osc_en  out  1  enables ring oscillator and counter.
REQ-011 cnt_clr  out  1  one-cycle synchronous clear of the counter.
REQ-012 tx_start  out  1  transmit request level.
REQ-013 tx_data  out  8  byte to transmit.
REQ-014 result  out  CW  latest averaged measurement.
REQ-015 result_valid  out  1  one-cycle pulse when result updates.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be: IDLE, ARM, GATE, SETTLE, CAPTURE, DIVIDE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
REQ-018 Commands (accepted in IDLE on rx_ready only): 0x4D 'M' starts a measurement; 0x4E 'N' makes the next received byte set log2n = byte[2:0], saturated to 4; 0x52 'R' resends the current result without measuring (enters SEND_LO); other bytes are ignored.
REQ-019 Bytes arriving while busy SHALL be ignored, except 0x58 'X', which aborts to IDLE next cycle with osc_en=0, tx_start=0, and result unchanged.
REQ-020 On 'M', the accumulator and sample index SHALL clear, then the block enters ARM.
REQ-021 ARM: cnt_clr=1 for exactly one cycle, osc_en=0; next state GATE.
REQ-022 GATE: osc_en=1 for exactly GATE_CYCLES cycles; then SETTLE.
REQ-023 SETTLE: osc_en=0 for SETTLE_CYCLES cycles; then CAPTURE.
REQ-024 CAPTURE (one cycle): acc += count with a zero-extended CW+4-bit accumulator that never wraps; idx++; if idx == 2^log2n, go to DIVIDE, else go to ARM.
REQ-025 DIVIDE (one cycle): result = acc >> log2n, truncated to CW bits; result_valid pulses; next state SEND_LO.
REQ-026 SEND_x: tx_data = result[7:0] (LO) or result[15:8] (HI); tx_start holds at 1 until tx_busy==1 is sampled, then the block enters WAIT_x.
REQ-027 WAIT_x: tx_start=0; tx_data holds; WAIT_LO leaves to SEND_HI, and WAIT_HI to IDLE, on the first cycle tx_busy==0.
REQ-028 In SEND_x, if tx_busy is already 1 on entry, the handshake is still satisfied; in WAIT_x, a byte is never re-sent.
REQ-029 The 'N' argument latch SHALL survive 'X'; an 'N' followed by 'X' discards the pending argument.
REQ-030 If reset and rx_ready are asserted in the same cycle, reset SHALL win.

Reset
REQ-031 On reset: state=IDLE; osc_en=0, cnt_clr=0, tx_start=0, tx_data=0, result=0, result_valid=0, busy=0; log2n=0; acc=0; idx=0; N-argument pending flag=0.
REQ-032 Reset asserted in any state, including mid-GATE or mid-transmit, SHALL produce the REQ-031 values on the next clk edge.

Structure
REQ-033 Command byte constants and state encodings SHALL reside in shared package tempsens_pkg.
REQ-034 A single sub-module, gate_timer (loadable down-counter with done flag), SHALL time both GATE and SETTLE.

Verification
REQ-035 log2n=0, count model returns 0x1234 at capture, 'M' -> result=0x1234, result_valid pulse, tx bytes 0x34 then 0x12.
REQ-036 'N',0x02 then 'M', captures 100,200,300,400 -> result=250 (0x00FA); exactly 4 cnt_clr pulses, each gate exactly GATE_CYCLES wide.
REQ-037 'N',0x07 -> log2n=4; captures of 16x0xFFFF -> result=0xFFFF with no accumulator wrap.
REQ-038 'X' sent during the second GATE window -> osc_en=0 next cycle, IDLE, no tx_start, result retains its previous value.
REQ-039 tx_busy held high for 50 cycles after first tx_start -> tx_start drops on the first cycle busy is seen, 0x12 is not sent until busy falls, and exactly 2 bytes total are sent.
REQ-040 reset asserted in WAIT_LO -> all outputs equal REQ-031 values next cycle; a subsequent 'R' sends 0x00,0x00.
